wb_arbiter: RTL and testbench

Writeback arbiter between the three functional units (ALU/Misc, Mem, Mult) and the single ARF write port. Each cycle it grants at most one register-writing completion. It drives the ARF write port and the scoreboard pending-clear one cycle after the grant. Non-writing completions (stores, writes to x0) retire immediately without using the port.

---
 rtl/wb_pkg.sv | 33 +++
 rtl/wb_rr_picker.sv | 35 +++
 rtl/wb_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback-arbiter definitions: unit encodings, request record, picker helpers.
package wb_pkg;

    localparam int NUM_UNITS = 3;

    localparam logic [1:0] UNIT_AM   = 2'b00;
    localparam logic [1:0] UNIT_MEM  = 2'b01;
    localparam logic [1:0] UNIT_MUL  = 2'b10;
    localparam logic [1:0] UNIT_NONE = 2'b11;

    typedef struct packed {
        logic        writereg;
        logic [4:0]  regdest;
        logic [31:0] data;
    } wb_req_t;

    // Unit visited at search position ofs, counting up (or down when rev) from base, mod 3.
    function automatic logic [1:0] unit_at(input logic [1:0] base, input logic [1:0] ofs,
                                           input logic rev);
        logic [2:0] b;
        logic [2:0] s;
        b = (base > UNIT_MUL) ? 3'd0 : {1'b0, base};
        if (rev) s = b + 3'd3 - {1'b0, ofs};
        else     s = b + {1'b0, ofs};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    function automatic logic [1:0] next_unit(input logic [1:0] u);
        return (u >= UNIT_MUL) ? UNIT_AM : u + 2'd1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational 3-way picker: first requester found searching from base (upward, or downward
// when REVERSE). Returns a one-hot grant and its index, UNIT_NONE when nothing requests.
module wb_rr_picker
    import wb_pkg::*;
#(
    parameter bit REVERSE = 1'b0
) (
    input  logic [NUM_UNITS-1:0] req,
    input  logic [1:0]           base,
    output logic [NUM_UNITS-1:0] gnt,
    output logic [1:0]           idx
);

    logic [1:0] cand [NUM_UNITS];
    logic [3:0] req_ext;
    logic [3:0] gnt_ext;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_cand
        assign cand[g] = unit_at(base, 2'(g), REVERSE);
    end

    assign req_ext = {1'b0, req};

    always_comb begin
        idx = UNIT_NONE;
        // Walk from the lowest priority up so the earliest match overwrites later ones.
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (req_ext[cand[i]]) idx = cand[i];
        end
    end

    assign gnt_ext = 4'b0001 << idx;
    assign gnt     = gnt_ext[NUM_UNITS-1:0];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one ARF write per cycle, registered one cycle after the grant; non-writing
// completions retire freely. Round-robin with WB_ARB_RR_EN, fixed MUL > MEM > AM otherwise.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             am_wb_valid,
    input  logic             mem_wb_valid,
    input  logic             mul_wb_valid,
    input  logic [4:0]       am_wb_regdest,
    input  logic [4:0]       mem_wb_regdest,
    input  logic [4:0]       mul_wb_regdest,
    input  logic [31:0]      am_wb_data,
    input  logic [31:0]      mem_wb_data,
    input  logic [31:0]      mul_wb_data,
    input  logic             am_wb_writereg,
    input  logic             mem_wb_writereg,
    input  logic             mul_wb_writereg,
    output logic             wb_am_ready,
    output logic             wb_mem_ready,
    output logic             wb_mul_ready,
    input  logic             wb_hold,
    output logic [4:0]       wb_reg_addr,
    output logic [31:0]      wb_reg_data,
    output logic             wb_reg_write,
    output logic [4:0]       wb_sb_addr,
    output logic             wb_sb_clear,
    output logic [CNT_W-1:0] wb_am_count,
    output logic [CNT_W-1:0] wb_mem_count,
    output logic [CNT_W-1:0] wb_mul_count,
    output logic             wb_idle
);

    wb_req_t              req [NUM_UNITS];
    logic [NUM_UNITS-1:0] vld;
    logic [NUM_UNITS-1:0] wreq;
    logic [NUM_UNITS-1:0] nreq;
    logic [NUM_UNITS-1:0] gnt;
    logic [NUM_UNITS-1:0] rdy;
    logic [1:0]           gnt_idx;
    logic [1:0]           pick_base;
    logic                 accept;
    logic                 grant_any;

    logic                 reg_write_q, reg_write_d;
    logic [4:0]           reg_addr_q,  reg_addr_d;
    logic [31:0]          reg_data_q,  reg_data_d;
    logic [CNT_W-1:0]     cnt_q [NUM_UNITS];
    logic [CNT_W-1:0]     cnt_d [NUM_UNITS];

    assign vld    = {mul_wb_valid, mem_wb_valid, am_wb_valid};
    assign req[0] = '{writereg: am_wb_writereg,  regdest: am_wb_regdest,  data: am_wb_data};
    assign req[1] = '{writereg: mem_wb_writereg, regdest: mem_wb_regdest, data: mem_wb_data};
    assign req[2] = '{writereg: mul_wb_writereg, regdest: mul_wb_regdest, data: mul_wb_data};

    always_comb begin
        for (int k = 0; k < NUM_UNITS; k++) begin
            wreq[k] = vld[k] & req[k].writereg & (req[k].regdest != 5'd0);
            nreq[k] = vld[k] & ~wreq[k];
        end
    end

`ifdef WB_ARB_RR_EN
    localparam bit PICK_REV = 1'b0;
    logic [1:0] rr_ptr_q, rr_ptr_d;

    assign pick_base = rr_ptr_q;
    assign rr_ptr_d  = grant_any ? next_unit(gnt_idx) : rr_ptr_q;

    always_ff @(posedge clock) begin
        if (reset) rr_ptr_q <= UNIT_AM;
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    // Downward search from MUL yields MUL > MEM > AM.
    localparam bit PICK_REV = 1'b1;
    assign pick_base = UNIT_MUL;
`endif

    wb_rr_picker #(.REVERSE(PICK_REV)) u_picker (
        .req  (wreq),
        .base (pick_base),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    assign accept    = ~reset & ~wb_hold;
    assign rdy       = {NUM_UNITS{accept}} & (nreq | gnt);
    assign grant_any = accept & (|gnt);

    always_comb begin
        reg_write_d = grant_any;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        if (grant_any) begin
            case (gnt_idx)
                UNIT_AM:  begin reg_addr_d = req[0].regdest; reg_data_d = req[0].data; end
                UNIT_MEM: begin reg_addr_d = req[1].regdest; reg_data_d = req[1].data; end
                UNIT_MUL: begin reg_addr_d = req[2].regdest; reg_data_d = req[2].data; end
                default:  ;
            endcase
        end
        for (int k = 0; k < NUM_UNITS; k++) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(rdy[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            reg_addr_q  <= 5'd0;
            reg_data_q  <= 32'd0;
            for (int k = 0; k < NUM_UNITS; k++) cnt_q[k] <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            for (int k = 0; k < NUM_UNITS; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign wb_am_ready  = rdy[0];
    assign wb_mem_ready = rdy[1];
    assign wb_mul_ready = rdy[2];
    assign wb_reg_write = reg_write_q;
    assign wb_sb_clear  = reg_write_q;
    assign wb_reg_addr  = reg_addr_q;
    assign wb_sb_addr   = reg_addr_q;
    assign wb_reg_data  = reg_data_q;
    assign wb_am_count  = cnt_q[0];
    assign wb_mem_count = cnt_q[1];
    assign wb_mul_count = cnt_q[2];
    assign wb_idle      = ~(|vld) & ~reg_write_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus reset, drain and counter-wrap sequences.
module tb_wb_arbiter;

    localparam int CNT_W = 4;
`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             am_wb_valid, mem_wb_valid, mul_wb_valid;
    logic [4:0]       am_wb_regdest, mem_wb_regdest, mul_wb_regdest;
    logic [31:0]      am_wb_data, mem_wb_data, mul_wb_data;
    logic             am_wb_writereg, mem_wb_writereg, mul_wb_writereg;
    logic             wb_am_ready, wb_mem_ready, wb_mul_ready;
    logic             wb_hold;
    logic [4:0]       wb_reg_addr, wb_sb_addr;
    logic [31:0]      wb_reg_data;
    logic             wb_reg_write, wb_sb_clear;
    logic [CNT_W-1:0] wb_am_count, wb_mem_count, wb_mul_count;
    logic             wb_idle;

    always #5 clock = ~clock;

    wb_arbiter #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .am_wb_valid(am_wb_valid), .mem_wb_valid(mem_wb_valid), .mul_wb_valid(mul_wb_valid),
        .am_wb_regdest(am_wb_regdest), .mem_wb_regdest(mem_wb_regdest),
        .mul_wb_regdest(mul_wb_regdest),
        .am_wb_data(am_wb_data), .mem_wb_data(mem_wb_data), .mul_wb_data(mul_wb_data),
        .am_wb_writereg(am_wb_writereg), .mem_wb_writereg(mem_wb_writereg),
        .mul_wb_writereg(mul_wb_writereg),
        .wb_am_ready(wb_am_ready), .wb_mem_ready(wb_mem_ready), .wb_mul_ready(wb_mul_ready),
        .wb_hold(wb_hold),
        .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data), .wb_reg_write(wb_reg_write),
        .wb_sb_addr(wb_sb_addr), .wb_sb_clear(wb_sb_clear),
        .wb_am_count(wb_am_count), .wb_mem_count(wb_mem_count), .wb_mul_count(wb_mul_count),
        .wb_idle(wb_idle)
    );

    typedef struct {
        logic        hold;
        logic [2:0]  vld;     // {MUL, MEM, AM}
        logic [2:0]  wr;
        logic [4:0]  rd0, rd1, rd2;
        logic [31:0] dam;
        logic [2:0]  rdy_fp;  // expected readies, fixed priority
        logic [2:0]  rdy_rr;  // expected readies, round-robin
    } vec_t;

    vec_t        tbl [12];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  cnt_m [3];
    logic        exp_wr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic hold, input logic [2:0] vld, input logic [2:0] wr,
                         input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        wb_hold         = hold;
        am_wb_valid     = vld[0]; mem_wb_valid    = vld[1]; mul_wb_valid    = vld[2];
        am_wb_writereg  = wr[0];  mem_wb_writereg = wr[1];  mul_wb_writereg = wr[2];
        am_wb_regdest   = rd0;    mem_wb_regdest  = rd1;    mul_wb_regdest  = rd2;
        am_wb_data      = d0;     mem_wb_data     = d1;     mul_wb_data     = d2;
    endtask

    task automatic check_stage(input string tag);
        chk({tag, "_reg_write"}, 32'(wb_reg_write), 32'(exp_wr));
        chk({tag, "_sb_clear"},  32'(wb_sb_clear),  32'(exp_wr));
        chk({tag, "_reg_addr"},  32'(wb_reg_addr),  32'(exp_addr));
        chk({tag, "_sb_addr"},   32'(wb_sb_addr),   32'(exp_addr));
        chk({tag, "_reg_data"},  wb_reg_data,       exp_data);
        chk({tag, "_am_count"},  32'(wb_am_count),  32'(cnt_m[0]));
        chk({tag, "_mem_count"}, 32'(wb_mem_count), 32'(cnt_m[1]));
        chk({tag, "_mul_count"}, 32'(wb_mul_count), 32'(cnt_m[2]));
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic apply(input vec_t v, input int i);
        logic [2:0]  er, wreq, wg;
        logic [31:0] d1, d2;
        d1 = 32'h2000_0000 + 32'(i);
        d2 = 32'h3000_0000 + 32'(i);
        drive(v.hold, v.vld, v.wr, v.rd0, v.rd1, v.rd2, v.dam, d1, d2);
        er = RR ? v.rdy_rr : v.rdy_fp;
        wreq[0] = v.vld[0] & v.wr[0] & (v.rd0 != 5'd0);
        wreq[1] = v.vld[1] & v.wr[1] & (v.rd1 != 5'd0);
        wreq[2] = v.vld[2] & v.wr[2] & (v.rd2 != 5'd0);
        wg = er & wreq;
        #1;
        chk($sformatf("v%0d_ready", i), 32'({wb_mul_ready, wb_mem_ready, wb_am_ready}), 32'(er));
        chk($sformatf("v%0d_idle", i), 32'(wb_idle), 32'((v.vld == 3'b000) && !exp_wr));
        @(posedge clock);
        @(negedge clock);
        exp_wr = (wg != 3'b000);
        if (wg[0]) begin exp_addr = v.rd0; exp_data = v.dam; end
        if (wg[1]) begin exp_addr = v.rd1; exp_data = d1; end
        if (wg[2]) begin exp_addr = v.rd2; exp_data = d2; end
        for (int k = 0; k < 3; k++) cnt_m[k] = cnt_m[k] + 4'(er[k]);
        check_stage($sformatf("v%0d", i));
    endtask

    initial begin
        logic [1:0] ord [3];
        logic [2:0] pending, one;

        //            hold  vld     wr      rd0    rd1    rd2    dam            fp      rr
        tbl[0]  = '{1'b0, 3'b111, 3'b111, 5'd5,  5'd6,  5'd7,  32'h1000_0000, 3'b100, 3'b001};
        tbl[1]  = '{1'b0, 3'b111, 3'b111, 5'd5,  5'd6,  5'd7,  32'h1000_0001, 3'b100, 3'b010};
        tbl[2]  = '{1'b0, 3'b111, 3'b111, 5'd5,  5'd6,  5'd7,  32'h1000_0002, 3'b100, 3'b100};
        tbl[3]  = '{1'b0, 3'b001, 3'b001, 5'd5,  5'd0,  5'd0,  32'hDEAD_BEEF, 3'b001, 3'b001};
        tbl[4]  = '{1'b0, 3'b111, 3'b101, 5'd8,  5'd9,  5'd10, 32'h1000_0004, 3'b110, 3'b110};
        tbl[5]  = '{1'b0, 3'b001, 3'b001, 5'd0,  5'd0,  5'd0,  32'h1000_0005, 3'b001, 3'b001};
        tbl[6]  = '{1'b1, 3'b111, 3'b111, 5'd11, 5'd12, 5'd13, 32'h1000_0006, 3'b000, 3'b000};
        tbl[7]  = '{1'b0, 3'b000, 3'b000, 5'd0,  5'd0,  5'd0,  32'h1000_0007, 3'b000, 3'b000};
        tbl[8]  = '{1'b0, 3'b111, 3'b110, 5'd14, 5'd15, 5'd16, 32'h1000_0008, 3'b101, 3'b011};
        tbl[9]  = '{1'b0, 3'b011, 3'b011, 5'd17, 5'd18, 5'd0,  32'h1000_0009, 3'b010, 3'b001};
        tbl[10] = '{1'b0, 3'b111, 3'b100, 5'd19, 5'd20, 5'd0,  32'h1000_000A, 3'b111, 3'b111};
        tbl[11] = '{1'b0, 3'b100, 3'b100, 5'd0,  5'd0,  5'd21, 32'h1000_000B, 3'b100, 3'b100};

        for (int k = 0; k < 3; k++) cnt_m[k] = 4'd0;
        exp_wr = 1'b0; exp_addr = 5'd0; exp_data = 32'd0;

        // Reset with every unit presenting a writing request.
        reset = 1'b1;
        drive(1'b0, 3'b111, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk("reset_ready", 32'({wb_mul_ready, wb_mem_ready, wb_am_ready}), 32'd0);
        end
        check_stage("reset");
        reset = 1'b0;

        for (int i = 0; i < 12; i++) apply(tbl[i], i);

        // Reset mid-operation drops the pending write and clears everything.
        drive(1'b0, 3'b001, 3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0);
        #1 chk("mid_am_ready", 32'(wb_am_ready), 32'd1);
        @(posedge clock); @(negedge clock);
        chk("mid_reg_write", 32'(wb_reg_write), 32'd1);
        chk("mid_reg_addr", 32'(wb_reg_addr), 32'd9);
        reset = 1'b1;
        #1 chk("mid_rst_ready", 32'({wb_mul_ready, wb_mem_ready, wb_am_ready}), 32'd0);
        @(posedge clock); @(negedge clock);
        for (int k = 0; k < 3; k++) cnt_m[k] = 4'd0;
        exp_wr = 1'b0; exp_addr = 5'd0; exp_data = 32'd0;
        check_stage("mid_rst");
        reset = 1'b0;

        // Three writers drain, each dropping valid once accepted.
        if (RR) begin ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; end
        else    begin ord[0] = 2'd2; ord[1] = 2'd1; ord[2] = 2'd0; end
        pending = 3'b111;
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, pending, 3'b111, 5'd20, 5'd21, 5'd22,
                  32'h4000_0000, 32'h4000_0001, 32'h4000_0002);
            one = 3'b001 << ord[s];
            #1 chk($sformatf("drain%0d_ready", s),
                   32'({wb_mul_ready, wb_mem_ready, wb_am_ready}), 32'(one));
            @(posedge clock); @(negedge clock);
            chk($sformatf("drain%0d_addr", s), 32'(wb_reg_addr), 32'd20 + 32'(ord[s]));
            chk($sformatf("drain%0d_data", s), wb_reg_data, 32'h4000_0000 + 32'(ord[s]));
            chk($sformatf("drain%0d_write", s), 32'(wb_reg_write), 32'd1);
            pending = pending & ~one;
        end
        chk("drain_am_count", 32'(wb_am_count), 32'd1);
        chk("drain_mem_count", 32'(wb_mem_count), 32'd1);
        chk("drain_mul_count", 32'(wb_mul_count), 32'd1);

        // AM count wraps: 1 + 15 transfers = 16 -> 0, then 1.
        for (int n = 0; n < 15; n++) begin
            drive(1'b0, 3'b001, 3'b001, 5'd3, 5'd0, 5'd0, 32'hA0 + 32'(n), 32'h0, 32'h0);
            @(posedge clock); @(negedge clock);
        end
        chk("wrap_am_count0", 32'(wb_am_count), 32'd0);
        chk("wrap_reg_data", wb_reg_data, 32'hAE);
        @(posedge clock); @(negedge clock);
        chk("wrap_am_count1", 32'(wb_am_count), 32'd1);
        chk("wrap_mem_count", 32'(wb_mem_count), 32'd1);
        drive(1'b0, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(posedge clock); @(negedge clock);
        chk("final_idle", 32'(wb_idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
